// File: rtl/bvinv_pkg.sv
// Shared definitions for the modular-multiply / unsigned-bound invariant checker.
package bvinv_pkg;

  // Default operand width for s, t and x.
  localparam int W_DEF = 4;

  // Checker control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result counters are 2W+1 bits wide.
  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/bvmul_seq.sv
// W-cycle shift-add multiplier, result taken modulo 2^W.
// A start pulse loads the operands. Each busy cycle consumes one bit of b,
// LSB first. done is high in the last step, and prod then shows the
// finished product.
module bvmul_seq
  import bvinv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] prod
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [W-1:0]     w_acc_nxt;

  // Partial-product add. The W-bit sum drops the carry, so the product wraps.
  always_comb begin
    w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
  end

  assign done = r_busy && (r_cnt == CNT_W'(W - 1));
  assign prod = w_acc_nxt;

  // Load on start; otherwise shift a up and b down once per busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_a    <= a;
      r_b    <= b;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_acc_nxt;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/bvule_bvmul_inv_check.sv
// Checks a Skolem candidate x against the invariant (x*s mod 2^W) <=u t.
// A triple is captured in IDLE and multiplied over W cycles. The result is
// held in DONE until the consumer takes it. Saturating counters tally how
// many results passed and how many failed.
module bvule_bvmul_inv_check
  import bvinv_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          s,
  input  logic [W-1:0]          t,
  input  logic [W-1:0]          x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_prod,
  output logic                  out_pass,
  output logic [cnt_w(W)-1:0]   pass_cnt,
  output logic [cnt_w(W)-1:0]   fail_cnt
);

  localparam int CW = cnt_w(W);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_e       r_state;
  logic [W-1:0] r_t;
  logic [W-1:0] r_prod;
  logic         r_pass;
  logic [CW-1:0] r_pass_cnt;
  logic [CW-1:0] r_fail_cnt;

  logic         w_accept;
  logic         w_hs;
  logic         w_mul_done;
  logic [W-1:0] w_prod;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_hs      = out_valid && out_ready;

  assign out_prod = r_prod;
  assign out_pass = r_pass;
  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;

  // s and x are latched inside the multiplier, so later input changes have no effect.
  bvmul_seq #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept),
    .a     (s),
    .b     (x),
    .done  (w_mul_done),
    .prod  (w_prod)
  );

  // Control FSM. The bound is captured here and the result is latched on leaving MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_prod  <= '0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_t     <= t;
          r_state <= ST_MUL;
        end
        ST_MUL: if (w_mul_done) begin
          r_prod  <= w_prod;
          r_pass  <= (w_prod <= r_t);
          r_state <= ST_DONE;
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Count each delivered result. Both counters saturate at their maximum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
    end else if (w_hs) begin
      if (r_pass) begin
        if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + 1'b1;
      end else begin
        if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + 1'b1;
      end
    end
  end

endmodule
